// File: rtl/ahb_resp_mux.sv
// ahb_resp_mux: AHB-Lite data-phase response multiplexer with a built-in
// default slave that answers decode errors with a two-cycle ERROR response.
//
// Ports:
//   HCLK, HRESETn    clock and synchronous active-low reset
//   hsel_addr        address-phase slave select (one-hot expected)
//   htrans           address-phase HTRANS
//   hrdata_in        per-slave HRDATA (packed, CHANNEL_NUM x DATA_W)
//   hreadyout_in     per-slave HREADYOUT
//   hresp_in         per-slave HRESP
//   hrdata_out       muxed HRDATA to master
//   hready_out       global HREADY
//   hresp_out        muxed HRESP
//   dec_err          one-cycle pulse per accepted decode error
//   err_cnt          saturating decode-error count
//
// Optional feature: define AHB_RESP_MUX_ERRCNT_EN to implement err_cnt;
// when undefined err_cnt is tied to zero.
module ahb_resp_mux #(
  parameter int unsigned CHANNEL_NUM = 4,
  parameter int unsigned DATA_W      = 32
) (
  input  logic                                HCLK,
  input  logic                                HRESETn,
  input  logic [CHANNEL_NUM-1:0]              hsel_addr,
  input  logic [1:0]                          htrans,
  input  logic [CHANNEL_NUM-1:0][DATA_W-1:0]  hrdata_in,
  input  logic [CHANNEL_NUM-1:0]              hreadyout_in,
  input  logic [CHANNEL_NUM-1:0]              hresp_in,
  output logic [DATA_W-1:0]                   hrdata_out,
  output logic                                hready_out,
  output logic                                hresp_out,
  output logic                                dec_err,
  output logic [7:0]                          err_cnt
);

  localparam int unsigned CntW = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ERR1 = 2'd1,
    ST_ERR2 = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [CHANNEL_NUM-1:0] dsel_q, dsel_d;
  logic                   dec_err_q, dec_err_d;
  logic                   trans_active;
  logic                   sel_onehot;

  // NONSEQ or SEQ request a transfer; IDLE and BUSY do not.
  always_comb begin
    trans_active = 1'b0;
    case (htrans)
      2'b10, 2'b11: trans_active = 1'b1;
      default:      trans_active = 1'b0;
    endcase
  end

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  assign sel_onehot = (|hsel_addr) &&
                      ((hsel_addr & (hsel_addr - CHANNEL_NUM'(1))) == '0);

  // Data-phase response: default slave in error states, otherwise the
  // selected slave, otherwise an idle OKAY with HREADY high.
  always_comb begin
    hrdata_out = '0;
    hready_out = 1'b1;
    hresp_out  = 1'b0;
    case (state_q)
      ST_ERR1: begin
        hready_out = 1'b0;
        hresp_out  = 1'b1;
      end
      ST_ERR2: begin
        hready_out = 1'b1;
        hresp_out  = 1'b1;
      end
      default: begin
        for (int unsigned i = 0; i < CHANNEL_NUM; i++) begin
          if (dsel_q[i]) begin
            hrdata_out = hrdata_in[i];
            hready_out = hreadyout_in[i];
            hresp_out  = hresp_in[i];
          end
        end
      end
    endcase
  end

  // Next-state: ERR1 always advances; otherwise the address phase is only
  // taken when the bus is ready, so slave wait states freeze dsel.
  always_comb begin
    state_d   = state_q;
    dsel_d    = dsel_q;
    dec_err_d = 1'b0;
    if (state_q == ST_ERR1) begin
      state_d = ST_ERR2;
    end else if (hready_out) begin
      if (trans_active && sel_onehot) begin
        dsel_d  = hsel_addr;
        state_d = ST_IDLE;
      end else if (trans_active) begin
        dsel_d    = '0;
        state_d   = ST_ERR1;
        dec_err_d = 1'b1;
      end else begin
        dsel_d  = '0;
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q   <= ST_IDLE;
      dsel_q    <= '0;
      dec_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dsel_q    <= dsel_d;
      dec_err_q <= dec_err_d;
    end
  end

  assign dec_err = dec_err_q;

`ifdef AHB_RESP_MUX_ERRCNT_EN
  logic [CntW-1:0] err_cnt_q;

  // Saturating decode-error counter, cleared only by reset.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      err_cnt_q <= '0;
    end else if (dec_err_d && (err_cnt_q != {CntW{1'b1}})) begin
      err_cnt_q <= err_cnt_q + CntW'(1);
    end
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = CntW'(0);
`endif

endmodule

// File: tb/tb_ahb_resp_mux.sv
// Directed self-checking bench for ahb_resp_mux (CHANNEL_NUM=4, DATA_W=32).
// Inputs change on the falling edge; outputs are checked 1 time unit later.
module tb_ahb_resp_mux;

`ifdef AHB_RESP_MUX_ERRCNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  logic              clk;
  logic              rst_n;
  logic [3:0]        hsel_addr;
  logic [1:0]        htrans;
  logic [3:0][31:0]  hrdata_in;
  logic [3:0]        hreadyout_in;
  logic [3:0]        hresp_in;
  logic [31:0]       hrdata_out;
  logic              hready_out;
  logic              hresp_out;
  logic              dec_err;
  logic [7:0]        err_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  ahb_resp_mux #(.CHANNEL_NUM(4), .DATA_W(32)) dut (
    .HCLK         (clk),
    .HRESETn      (rst_n),
    .hsel_addr    (hsel_addr),
    .htrans       (htrans),
    .hrdata_in    (hrdata_in),
    .hreadyout_in (hreadyout_in),
    .hresp_in     (hresp_in),
    .hrdata_out   (hrdata_out),
    .hready_out   (hready_out),
    .hresp_out    (hresp_out),
    .dec_err      (dec_err),
    .err_cnt      (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic next_cyc();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst_n        = 1'b0;
    hsel_addr    = 4'b0000;
    htrans       = 2'b00;
    hrdata_in[0] = 32'h1111_1111;
    hrdata_in[1] = 32'h2222_2222;
    hrdata_in[2] = 32'hDEAD_BEEF;
    hrdata_in[3] = 32'h4444_4444;
    hreadyout_in = 4'b1111;
    hresp_in     = 4'b0000;

    // Reset state
    repeat (2) @(posedge clk);
    next_cyc(); rst_n = 1'b1; settle();
    check_eq("rst_ready", hready_out, 1);
    check_eq("rst_resp",  hresp_out, 0);
    check_eq("rst_rdata", hrdata_out, 0);
    check_eq("rst_decerr", dec_err, 0);
    check_eq("rst_errcnt", err_cnt, 0);

    // NONSEQ to slave 2, data on the following cycle
    htrans = 2'b10; hsel_addr = 4'b0100;
    next_cyc(); htrans = 2'b00; hsel_addr = 4'b0000; settle();
    check_eq("s2_rdata", hrdata_out, 32'hDEAD_BEEF);
    check_eq("s2_ready", hready_out, 1);
    check_eq("s2_resp",  hresp_out, 0);
    next_cyc(); settle();
    check_eq("idle_rdata", hrdata_out, 0);
    check_eq("idle_ready", hready_out, 1);

    // Slave 1 stalls for 3 cycles while the decoder moves to slave 0
    htrans = 2'b10; hsel_addr = 4'b0010; hreadyout_in[1] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      next_cyc(); hsel_addr = 4'b0001; settle();
      check_eq("stall_ready", hready_out, 0);
      check_eq("stall_rdata", hrdata_out, 32'h2222_2222);
    end
    next_cyc(); hreadyout_in[1] = 1'b1; settle();
    check_eq("stall_end_ready", hready_out, 1);
    check_eq("stall_end_rdata", hrdata_out, 32'h2222_2222);
    next_cyc(); htrans = 2'b00; hsel_addr = 4'b0000; settle();
    check_eq("s0_rdata", hrdata_out, 32'h1111_1111);
    check_eq("s0_ready", hready_out, 1);

    // SEQ to slave 3 returning ERROR from the slave itself
    next_cyc(); htrans = 2'b11; hsel_addr = 4'b1000; hresp_in[3] = 1'b1;
    next_cyc(); htrans = 2'b00; hsel_addr = 4'b0000; settle();
    check_eq("s3_rdata", hrdata_out, 32'h4444_4444);
    check_eq("s3_resp",  hresp_out, 1);
    check_eq("s3_decerr", dec_err, 0);
    next_cyc(); hresp_in[3] = 1'b0;

    // Decode error with no select, then back-to-back multi-hot error
    htrans = 2'b10; hsel_addr = 4'b0000;
    next_cyc(); htrans = 2'b00; settle();
    check_eq("e1_ready", hready_out, 0);
    check_eq("e1_resp",  hresp_out, 1);
    check_eq("e1_rdata", hrdata_out, 0);
    check_eq("e1_decerr", dec_err, 1);
    next_cyc(); htrans = 2'b10; hsel_addr = 4'b0011; settle();
    check_eq("e2_ready", hready_out, 1);
    check_eq("e2_resp",  hresp_out, 1);
    check_eq("e2_decerr", dec_err, 0);
    next_cyc(); htrans = 2'b00; hsel_addr = 4'b0000; settle();
    check_eq("mh_e1_ready", hready_out, 0);
    check_eq("mh_e1_resp",  hresp_out, 1);
    check_eq("mh_e1_decerr", dec_err, 1);
    next_cyc(); settle();
    check_eq("mh_e2_ready", hready_out, 1);
    check_eq("mh_e2_resp",  hresp_out, 1);
    check_eq("mh_e2_decerr", dec_err, 0);
    check_eq("errcnt_2", err_cnt, CntEn ? 64'd2 : 64'd0);
    next_cyc(); settle();
    check_eq("post_err_ready", hready_out, 1);
    check_eq("post_err_resp",  hresp_out, 0);

    // 258 more decode errors (260 total): counter must saturate
    htrans = 2'b10; hsel_addr = 4'b0000;
    repeat (2 * 258) next_cyc();
    htrans = 2'b00;
    next_cyc(); settle();
    check_eq("sat_ready", hready_out, 1);
    check_eq("sat_resp",  hresp_out, 0);
    check_eq("errcnt_sat", err_cnt, CntEn ? 64'd255 : 64'd0);

    // Reset asserted during ERR1
    htrans = 2'b10; hsel_addr = 4'b0000;
    next_cyc(); htrans = 2'b00; rst_n = 1'b0; settle();
    check_eq("pre_rst_ready", hready_out, 0);
    next_cyc(); rst_n = 1'b1; settle();
    check_eq("err_rst_ready", hready_out, 1);
    check_eq("err_rst_resp",  hresp_out, 0);
    check_eq("err_rst_decerr", dec_err, 0);
    check_eq("err_rst_errcnt", err_cnt, 0);

    // BUSY with a select present is not a transfer
    htrans = 2'b01; hsel_addr = 4'b1000;
    next_cyc(); htrans = 2'b00; hsel_addr = 4'b0000; settle();
    check_eq("busy_ready", hready_out, 1);
    check_eq("busy_resp",  hresp_out, 0);
    check_eq("busy_rdata", hrdata_out, 0);
    check_eq("busy_decerr", dec_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_resp_mux.md
AHB_RESP_MUX -- requirements
Module: ahb_resp_mux

Interface
REQ-001 SHALL have parameter CHANNEL_NUM, default 4, number of slave response channels (1..16).
REQ-002 SHALL have parameter DATA_W, default 32, HRDATA width (32 or 64).
REQ-003 SHALL have one clock and a synchronous, active-low reset:
  HCLK  input  1  system clock, all state on rising edge
  HRESETn  input  1  synchronous active-low reset
REQ-004 SHALL have these ports:
  hsel_addr  input  CHANNEL_NUM  address-phase slave select from decoder, one-hot expected
  htrans  input  2  address-phase HTRANS
  hrdata_in  input  CHANNEL_NUM x DATA_W  per-slave HRDATA
  hreadyout_in  input  CHANNEL_NUM  per-slave HREADYOUT
  hresp_in  input  CHANNEL_NUM  per-slave HRESP (0 OKAY, 1 ERROR)
  hrdata_out  output  DATA_W  muxed HRDATA to master
  hready_out  output  1  global HREADY
  hresp_out  output  1  muxed HRESP
  dec_err  output  1  one-cycle pulse on each decode error accepted
  err_cnt  output  8  decode-error count (see Configuration)

Function
REQ-005 SHALL hold data-phase select register dsel (CHANNEL_NUM bits) and default-slave FSM state {IDLE, ERR1, ERR2}.
REQ-006 SHALL sample the address phase only in cycles where hready_out=1; otherwise dsel and FSM hold.
REQ-007 Valid transfer: htrans in {NONSEQ=10, SEQ=11} and hsel_addr exactly one-hot -> dsel <= hsel_addr, FSM stays IDLE.
REQ-008 Decode error: htrans in {10,11} and hsel_addr zero or multi-hot -> dsel <= 0, FSM -> ERR1, dec_err=1 for the next cycle.
REQ-009 IDLE/BUSY (htrans 00/01) -> dsel <= 0, FSM IDLE.
REQ-010 With dsel one-hot bit i: hrdata_out=hrdata_in[i], hready_out=hreadyout_in[i], hresp_out=hresp_in[i], combinationally from slave inputs (zero added latency in data phase).
REQ-011 With dsel=0 and FSM IDLE: hrdata_out=0, hready_out=1, hresp_out=0.
REQ-012 ERR1: hready_out=0, hresp_out=1, hrdata_out=0; unconditionally -> ERR2 next cycle.
REQ-013 ERR2: hready_out=1, hresp_out=1, hrdata_out=0; address phase sampled per REQ-007..009 (back-to-back error re-enters ERR1).
REQ-014 Select to data-phase latency SHALL be exactly one accepted (hready_out=1) cycle.
REQ-015 Slave wait states (hreadyout_in[i]=0) SHALL stall dsel; a new hsel_addr during stall SHALL be ignored until the stall ends.

Reset
REQ-016 On HRESETn=0 at a rising edge: dsel=0, FSM=IDLE, dec_err=0, err_cnt=0; outputs then hrdata_out=0, hready_out=1, hresp_out=0.
REQ-017 Reset asserted mid-ERR1/ERR2 or mid slave stall SHALL abandon the transfer and return to REQ-016 state next cycle.

Configuration
REQ-018 Macro AHB_RESP_MUX_ERRCNT_EN defined: err_cnt increments by 1 on each decode error accepted (REQ-008), saturating at 255, cleared only by reset.
REQ-019 Macro undefined: counter not implemented, err_cnt tied to 0; all other behaviour identical.

Verification
REQ-020 Reset then NONSEQ with hsel_addr=0100, hrdata_in[2]=0xDEADBEEF, hreadyout_in[2]=1 -> next cycle hrdata_out=0xDEADBEEF, hready_out=1, hresp_out=0.
REQ-021 NONSEQ to slave 1, hreadyout_in[1]=0 for 3 cycles while hsel_addr changes to 0001 -> hready_out=0 for 3 cycles, dsel stays 0010, slave 0 selected only after stall.
REQ-022 NONSEQ with hsel_addr=0000 -> ERR1 (hready_out=0,hresp_out=1), ERR2 (hready_out=1,hresp_out=1), dec_err pulses once; repeat with hsel_addr=0011 -> same, err_cnt=2 when macro defined, 0 when not.
REQ-023 256+4 consecutive decode errors with AHB_RESP_MUX_ERRCNT_EN -> err_cnt saturates at 255.
REQ-024 HRESETn=0 during ERR1 -> next cycle hready_out=1, hresp_out=0, FSM IDLE, err_cnt=0.
REQ-025 BUSY (01) with hsel_addr=1000 -> next cycle hready_out=1, hresp_out=0, hrdata_out=0, no dec_err.
